key_cmd_queue: RTL and testbench
================================

// Module: key_cmd_queue
// PURPOSE
//  Downstream of the PS/2 keyboard driver. Filters its 8-bit ASCII key output ('1'..'8').
//  Detects new key values and converts them to 3-bit move/select command codes.
//  Queues the codes in a small FIFO and hands them to the HuarongDao game FSM over a valid/ready handshake.
//  Decouples game-logic stalls (animation, redraw) from keyboard timing; no key is lost unless the FIFO is full.
// PARAMETERS
//  STABLE_CYCLES  1000  consecutive identical synced samples required before a value is accepted (>=1)
//  DEPTH          4     FIFO entries; power of two, >=2
// PORTS
//  I_clk_100M    in   1              system clock, 100 MHz
//  I_rst         in   1              asynchronous reset, active-high; all state cleared immediately
//  I_key_ascii   in   8              ASCII key value from keyboard driver; treated as asynchronous
//  I_cmd_ready   in   1              game FSM accepts the head command this cycle
//  O_cmd_valid   out  1              FIFO non-empty; O_cmd holds the head entry
//  O_cmd         out  3              command code = key_ascii - 8'h31 ('1'->0 ... '8'->7)
//  O_fifo_cnt    out  $clog2(DEPTH)+1  number of queued entries
//  O_drop_cnt    out  8              events dropped because the FIFO was full (only with KEY_DROP_CNT_EN)
// BEHAVIOUR
//  Reset values: O_cmd_valid=0, O_cmd=0, O_fifo_cnt=0, O_drop_cnt=0, sync regs=0, last_stable=0, stab_cnt=0.
//  Sync: I_key_ascii passes through two flops to produce s. The bus is sampled as a whole; multi-bit skew is absorbed by the stability filter.
//  Stability filter:
//   - If s != s_prev, stab_cnt is set to 0.
//   - Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
//   - The settle event fires on the single cycle stab_cnt steps to STABLE_CYCLES.
//  Settle event: last_stable <= s always. A push request is issued only if s is in 8'h31..8'h38 AND s != the old last_stable.
//   - 0 and out-of-range values never push, but they do update last_stable.
//   - An intervening 0 or other value therefore re-arms a repeated key.
//   - A value that is held indefinitely pushes exactly once.
//  Push request is registered one cycle, then written to the FIFO.
//  Latency: I_key_ascii changes at edge 0 and is held, with the FIFO empty:
//   - O_cmd_valid rises at edge STABLE_CYCLES+3.
//   - O_cmd is valid in the same cycle.
//  FIFO: DEPTH-entry circular buffer with wr_ptr/rd_ptr. Pointers wrap modulo DEPTH. Extra count bit distinguishes full from empty.
//  Pop occurs when O_cmd_valid && I_cmd_ready. The head advances on the next edge; O_cmd shows the new head or holds the last value when empty.
//  Empty: I_cmd_ready is ignored. O_cmd_valid stays 0 until a push lands.
//  Full without pop: push is discarded; FIFO contents are unchanged.
//  Full with a pop in the same cycle: the push is accepted; count stays DEPTH.
//  Push and pop in the same cycle at any other count: both are performed; count is unchanged.
//  O_cmd_valid and O_cmd do not depend combinationally on I_cmd_ready; both are registered or FIFO-read outputs.
//  Reset mid-operation (async assert): FIFO is emptied, filter is cleared, any in-flight push is lost.
//   - After release, a key held through reset is re-accepted once s is stable, because last_stable=0.
// CONFIGURATION
//  KEY_DROP_CNT_EN defined:
//   - O_drop_cnt increments by 1 on each discarded push (full and no pop).
//   - The counter saturates at 8'hFF and is cleared only by I_rst.
//  KEY_DROP_CNT_EN undefined: O_drop_cnt is tied to 8'h00 and no counter logic is built.
// TESTING  (bench uses STABLE_CYCLES=4, DEPTH=4)
//  Single key: I_key_ascii=8'h33 held, I_cmd_ready=0 -> O_cmd_valid rises at edge 7 with O_cmd=3'd2 and O_fifo_cnt=1.
//   - Holding the value for 100 more cycles produces no second entry.
//  Glitch reject: 8'h35 for 3 cycles, then 8'h00 -> no push; O_fifo_cnt stays 0.
//  Repeat key: '1', 0, '1', each held 10 cycles, with I_cmd_ready=1 -> exactly two handshakes, each with O_cmd=0.
//   - Sequence '1','1' with no gap -> exactly one handshake.
//  Overflow: keys '1'..'6' separated by 0 gaps, I_cmd_ready=0 -> O_fifo_cnt=4; drain order is 0,1,2,3.
//   - With KEY_DROP_CNT_EN, O_drop_cnt=2; without it, O_drop_cnt=0.
//  Full + simultaneous pop: push lands on the same edge as a pop -> count stays 4, and the new code appears last on drain.
//  Async reset: assert I_rst mid-queue (count 3), asynchronously to the clock -> outputs drop to 0 with no clock edge.
//   - After release with '8' still held -> O_cmd=7 appears at edge 7 after release.

Source files
------------

// File: rtl/key_cmd_queue.sv
// key_cmd_queue: synchronises and debounces the PS/2 ASCII key bus, turns
// newly settled keys '1'..'8' into 3-bit command codes and queues them for
// the game FSM behind a valid/ready handshake.
// Optional build macro: KEY_DROP_CNT_EN builds the saturating drop counter
// on O_drop_cnt. Without it O_drop_cnt is tied to zero.
module key_cmd_queue #(
  parameter int STABLE_CYCLES = 1000,
  parameter int DEPTH         = 4
) (
  input  logic                     I_clk_100M,
  input  logic                     I_rst,
  input  logic [7:0]               I_key_ascii,
  input  logic                     I_cmd_ready,
  output logic                     O_cmd_valid,
  output logic [2:0]               O_cmd,
  output logic [$clog2(DEPTH):0]   O_fifo_cnt,
  output logic [7:0]               O_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; s_q is the synchronised sample s.
  // ---------------------------------------------------------------------------
  logic [7:0] sync1_q, s_q;

  // Bring the asynchronous key bus into the clock domain as a whole word.
  always_ff @(posedge I_clk_100M or posedge I_rst) begin
    if (I_rst) begin
      sync1_q <= 8'h00;
      s_q     <= 8'h00;
    end else begin
      sync1_q <= I_key_ascii;
      s_q     <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stability filter. The counter restarts on the edge where s changes
  // (the incoming sample differs from the current s), so it counts the edges
  // s has held its value. Settle fires once, on the step to STABLE_CYCLES.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] stab_q, stab_d;
  logic [7:0]    last_q;
  logic          push_q, push_d;
  logic [2:0]    code_q;
  logic          same, settle, in_range;

  assign same     = (sync1_q == s_q);
  assign settle   = same && (stab_q == STAB_LAST);
  assign in_range = (s_q >= 8'h31) && (s_q <= 8'h38);
  assign push_d   = settle && in_range && (s_q != last_q);

  // Next stability count: restart on change, saturate once settled.
  always_comb begin
    stab_d = stab_q;
    if (!same)
      stab_d = '0;
    else if (stab_q != STAB_MAX)
      stab_d = stab_q + SW'(1);
  end

  // Filter state plus the registered push request and its command code.
  always_ff @(posedge I_clk_100M or posedge I_rst) begin
    if (I_rst) begin
      stab_q <= '0;
      last_q <= 8'h00;
      push_q <= 1'b0;
      code_q <= 3'd0;
    end else begin
      stab_q <= stab_d;
      if (settle)
        last_q <= s_q;
      push_q <= push_d;
      // '1'..'8' have low bits 1..7,0, so subtracting one mod 8 gives 0..7.
      code_q <= s_q[2:0] - 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FIFO. Outputs are registered from the next-state head so that
  // valid/cmd never depend combinationally on I_cmd_ready.
  // ---------------------------------------------------------------------------
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [2:0]    cmd_q, cmd_d, head_d;
  logic          pop, full, wr_en;

  assign pop   = valid_q && I_cmd_ready;
  assign full  = (cnt_q == FULL_CNT);
  assign wr_en = push_q && (!full || pop);

  // Next pointers, count and head; bypass the write when it becomes the head.
  always_comb begin
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(wr_en);
    cnt_d   = cnt_q + CW'(wr_en) - CW'(pop);
    head_d  = (wr_en && (wr_q == rd_d)) ? code_q : mem_q[rd_d];
    valid_d = (cnt_d != '0);
    cmd_d   = valid_d ? head_d : cmd_q;
  end

  // FIFO storage, pointers and registered outputs.
  always_ff @(posedge I_clk_100M or posedge I_rst) begin
    if (I_rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= 3'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      cmd_q   <= 3'd0;
    end else begin
      if (wr_en)
        mem_q[wr_q] <= code_q;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
    end
  end

  assign O_cmd_valid = valid_q;
  assign O_cmd       = cmd_q;
  assign O_fifo_cnt  = cnt_q;

`ifdef KEY_DROP_CNT_EN
  logic [7:0] drop_q;

  // Count pushes discarded because the queue was full with no pop; saturate.
  always_ff @(posedge I_clk_100M or posedge I_rst) begin
    if (I_rst)
      drop_q <= 8'h00;
    else if (push_q && full && !pop && (drop_q != 8'hFF))
      drop_q <= drop_q + 8'd1;
  end

  assign O_drop_cnt = drop_q;
`else
  assign O_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_key_cmd_queue.sv
// Directed bench for key_cmd_queue with STABLE_CYCLES=4, DEPTH=4.
module tb_key_cmd_queue;

`ifdef KEY_DROP_CNT_EN
  localparam int EXP_DROP = 2;
`else
  localparam int EXP_DROP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key;
  logic       ready;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [2:0] fifo_cnt;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  int hs_codes [0:15];
  int hs_base;

  key_cmd_queue #(.STABLE_CYCLES(4), .DEPTH(4)) dut (
    .I_clk_100M (clk),
    .I_rst      (rst),
    .I_key_ascii(key),
    .I_cmd_ready(ready),
    .O_cmd_valid(cmd_valid),
    .O_cmd      (cmd),
    .O_fifo_cnt (fifo_cnt),
    .O_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Record every handshake the DUT completes.
  always @(posedge clk) begin
    if (!rst && cmd_valid && ready) begin
      if (hs_cnt < 16) hs_codes[hs_cnt] = int'(cmd);
      hs_cnt = hs_cnt + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [7:0] k, input int n);
    key = k;
    tick(n);
  endtask

  initial begin
    rst = 1'b1; key = 8'h00; ready = 1'b0;
    tick(2);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_cmd",   int'(cmd), 0);
    check("rst_cnt",   int'(fifo_cnt), 0);
    check("rst_drop",  int'(drop_cnt), 0);
    #2 rst = 1'b0;
    tick(10);

    // Single key: valid at edge 7 after the change.
    key = 8'h33;
    tick(6);
    check("single_early_valid", int'(cmd_valid), 0);
    tick(1);
    check("single_valid", int'(cmd_valid), 1);
    check("single_cmd",   int'(cmd), 2);
    check("single_cnt",   int'(fifo_cnt), 1);
    tick(100);
    check("single_held_cnt", int'(fifo_cnt), 1);
    ready = 1'b1; tick(1); ready = 1'b0;
    check("single_pop_cnt",   int'(fifo_cnt), 0);
    check("single_pop_valid", int'(cmd_valid), 0);
    check("single_pop_hold",  int'(cmd), 2);
    hold(8'h00, 10);

    // Empty queue ignores ready.
    ready = 1'b1; tick(3); ready = 1'b0;
    check("empty_ready_cnt",   int'(fifo_cnt), 0);
    check("empty_ready_valid", int'(cmd_valid), 0);

    // Glitch shorter than the filter.
    hold(8'h35, 3);
    hold(8'h00, 10);
    check("glitch_cnt", int'(fifo_cnt), 0);

    // Repeat key re-armed by a zero gap.
    hs_base = hs_cnt;
    ready = 1'b1;
    hold(8'h31, 10); hold(8'h00, 10); hold(8'h31, 10); hold(8'h00, 10);
    check("repeat_hs", hs_cnt - hs_base, 2);
    check("repeat_code0", hs_codes[hs_base], 0);
    check("repeat_code1", hs_codes[hs_base + 1], 0);
    hs_base = hs_cnt;
    hold(8'h31, 20); hold(8'h00, 10);
    check("nogap_hs", hs_cnt - hs_base, 1);
    ready = 1'b0;

    // Overflow: six keys into a four-deep queue.
    for (int k = 1; k <= 6; k++) begin
      hold(8'h30 + 8'(k), 8);
      hold(8'h00, 8);
    end
    check("ovf_cnt",  int'(fifo_cnt), 4);
    check("ovf_drop", int'(drop_cnt), EXP_DROP);
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain", int'(cmd), i);
      ready = 1'b1; tick(1); ready = 1'b0;
    end
    check("ovf_empty", int'(fifo_cnt), 0);

    // Full queue with a pop on the same edge as the push.
    for (int k = 1; k <= 4; k++) begin
      hold(8'h30 + 8'(k), 8);
      hold(8'h00, 8);
    end
    check("fullpop_pre_cnt", int'(fifo_cnt), 4);
    key = 8'h35;
    tick(6);
    ready = 1'b1; tick(1); ready = 1'b0;
    check("fullpop_cnt",  int'(fifo_cnt), 4);
    check("fullpop_head", int'(cmd), 1);
    check("fullpop_drop", int'(drop_cnt), EXP_DROP);
    hold(8'h00, 4);
    for (int i = 1; i <= 4; i++) begin
      check("fullpop_drain", int'(cmd), i);
      ready = 1'b1; tick(1); ready = 1'b0;
    end
    check("fullpop_empty", int'(fifo_cnt), 0);

    // Asynchronous reset with three entries queued and '8' held.
    hold(8'h31, 8); hold(8'h00, 8);
    hold(8'h32, 8); hold(8'h00, 8);
    hold(8'h38, 8);
    check("arst_pre_cnt", int'(fifo_cnt), 3);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", int'(cmd_valid), 0);
    check("arst_cmd",   int'(cmd), 0);
    check("arst_cnt",   int'(fifo_cnt), 0);
    check("arst_drop",  int'(drop_cnt), 0);
    #2 rst = 1'b0;
    tick(6);
    check("arst_early_valid", int'(cmd_valid), 0);
    tick(1);
    check("arst_valid_back", int'(cmd_valid), 1);
    check("arst_cmd_back",   int'(cmd), 7);
    check("arst_cnt_back",   int'(fifo_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
